// File: rtl/sprite_line_buffer_if.sv
// Sprite line buffer bus: load strobes and pattern data from the fetch
// sequencer in, prioritised sprite pixel out to the pixel mixer.
// Handshake: there is no valid/ready flow control. Every strobe
// (next_pixel, line_clear, pattern0_ld, pattern1_ld) is a single-cycle
// qualifier that the buffer always accepts on the rising clock edge. The
// outputs are always valid and are a combinational view of registered state.
interface sprite_line_buffer_if #(
  parameter int X_WIDTH = 8,
  parameter int SLOT_W  = 3
);
  logic               bground_read;
  logic               next_pixel;
  logic               line_clear;
  logic [SLOT_W-1:0]  load_slot;
  logic               pattern0_ld;
  logic               pattern1_ld;
  logic               valid_sprite;
  logic [3:0]         sprite_attr_in;
  logic [X_WIDTH-1:0] sprite_x_in;
  logic [7:0]         pattern_in;
  logic [3:0]         sprite_pixel;
  logic               sprite_priority;
  logic [SLOT_W-1:0]  sprite_slot;
  logic               sprite0_opaque;

  modport master (
    output bground_read, next_pixel, line_clear, load_slot, pattern0_ld,
           pattern1_ld, valid_sprite, sprite_attr_in, sprite_x_in, pattern_in,
    input  sprite_pixel, sprite_priority, sprite_slot, sprite0_opaque
  );

  modport slave (
    input  bground_read, next_pixel, line_clear, load_slot, pattern0_ld,
           pattern1_ld, valid_sprite, sprite_attr_in, sprite_x_in, pattern_in,
    output sprite_pixel, sprite_priority, sprite_slot, sprite0_opaque
  );
endinterface

// File: rtl/sprite_line_buffer.sv
// Multi-slot sprite line buffer. Each slot holds one sprite for the next
// scanline: an X down-counter delays the sprite, then two pattern shifters
// emit eight pixels MSB first. A fixed-priority mux (slot 0 highest) picks
// the front-most opaque pixel every dot.
module sprite_line_buffer #(
  parameter int NUM_SLOTS = 8,
  parameter int X_WIDTH   = 8,
  parameter int SLOT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  sprite_line_buffer_if.slave bus
);

  // Per-slot state
  logic [NUM_SLOTS-1:0] r_valid;
  logic [NUM_SLOTS-1:0] r_armed;
  logic [3:0]           r_attr     [NUM_SLOTS];
  logic [X_WIDTH-1:0]   r_xcnt     [NUM_SLOTS];
  logic [7:0]           r_lsb_sh   [NUM_SLOTS];
  logic [7:0]           r_msb_sh   [NUM_SLOTS];
  logic [7:0]           r_lsb_hold [NUM_SLOTS];
  logic [3:0]           r_shcnt    [NUM_SLOTS];

  logic                 w_adv;
  logic [NUM_SLOTS-1:0] w_active;
  logic [NUM_SLOTS-1:0] w_opaque;
  logic [3:0]           w_pixel;
  logic                 w_priority;
  logic [SLOT_W-1:0]    w_slot;

  // Horizontal flip is resolved once at load time so the shifters only
  // ever shift left.
  function automatic logic [7:0] bit_rev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  assign w_adv = bus.next_pixel & bus.bground_read;

  // Slot is showing pixels: armed, real sprite, X reached, not exhausted.
  always_comb begin
    w_active = '0;
    w_opaque = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      w_active[s] = r_armed[s] & r_valid[s] & (r_xcnt[s] == '0) & (r_shcnt[s] < 4'd8);
      w_opaque[s] = w_active[s] & (r_msb_sh[s][7] | r_lsb_sh[s][7]);
    end
  end

  // Slot state: clear beats loads, pattern0 beats pattern1, loads beat advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_armed <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_attr[s]     <= '0;
        r_xcnt[s]     <= '0;
        r_lsb_sh[s]   <= '0;
        r_msb_sh[s]   <= '0;
        r_lsb_hold[s] <= '0;
        r_shcnt[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (bus.line_clear) begin
          r_valid[s] <= 1'b0;
          r_armed[s] <= 1'b0;
        end else if (bus.pattern0_ld && (bus.load_slot == SLOT_W'(s))) begin
          r_valid[s]    <= bus.valid_sprite;
          r_attr[s]     <= bus.sprite_attr_in;
          r_xcnt[s]     <= bus.sprite_x_in;
          r_armed[s]    <= 1'b0;
          r_lsb_hold[s] <= bus.sprite_attr_in[3] ? bit_rev(bus.pattern_in) : bus.pattern_in;
        end else if (bus.pattern1_ld && (bus.load_slot == SLOT_W'(s))) begin
          r_lsb_sh[s] <= r_lsb_hold[s];
          r_msb_sh[s] <= r_attr[s][3] ? bit_rev(bus.pattern_in) : bus.pattern_in;
          r_shcnt[s]  <= 4'd0;
          r_armed[s]  <= 1'b1;
        end else if (w_adv && r_armed[s]) begin
          if (r_xcnt[s] != '0) begin
            r_xcnt[s] <= r_xcnt[s] - 1'b1;
          end else if (r_shcnt[s] < 4'd8) begin
            r_lsb_sh[s] <= {r_lsb_sh[s][6:0], 1'b0};
            r_msb_sh[s] <= {r_msb_sh[s][6:0], 1'b0};
            r_shcnt[s]  <= r_shcnt[s] + 4'd1;
          end
        end
      end
    end
  end

  // Priority mux: scan from lowest priority up so the lowest opaque index wins.
  always_comb begin
    w_pixel    = 4'b0000;
    w_priority = 1'b0;
    w_slot     = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (w_opaque[s]) begin
        w_pixel    = {r_attr[s][1:0], r_msb_sh[s][7], r_lsb_sh[s][7]};
        w_priority = r_attr[s][2];
        w_slot     = SLOT_W'(s);
      end
    end
  end

  assign bus.sprite_pixel    = w_pixel;
  assign bus.sprite_priority = w_priority;
  assign bus.sprite_slot     = w_slot;
  assign bus.sprite0_opaque  = w_opaque[0];

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Bench for sprite_line_buffer: directed scenarios plus randomized lines
// checked against a dot-count model of sprite placement.
module tb_sprite_line_buffer;
  localparam int N  = 8;
  localparam int XW = 8;
  localparam int SW = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_line_buffer_if #(.X_WIDTH(XW), .SLOT_W(SW)) bus ();

  sprite_line_buffer #(.NUM_SLOTS(N), .X_WIDTH(XW), .SLOT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // observed output bundle: {pixel[3:0], priority, slot[2:0], sprite0_opaque}
  wire [8:0] obs = {bus.sprite_pixel, bus.sprite_priority, bus.sprite_slot, bus.sprite0_opaque};

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  // reference model: each slot remembers its sprite and how many dots have
  // elapsed since it was armed; pixel i of the sprite is visible on dot x+i.
  bit         m_valid [N];
  bit         m_armed [N];
  bit         m_flip  [N];
  bit         m_pri   [N];
  logic [1:0] m_pal   [N];
  logic [7:0] m_lo    [N];
  logic [7:0] m_hi    [N];
  int         m_x     [N];
  int         m_cnt   [N];

  task automatic model_reset();
    for (int s = 0; s < N; s++) begin
      m_valid[s] = 0; m_armed[s] = 0; m_flip[s] = 0; m_pri[s] = 0;
      m_pal[s] = 0; m_lo[s] = 0; m_hi[s] = 0; m_x[s] = 0; m_cnt[s] = 0;
    end
  endtask

  task automatic model_step();
    bit adv;
    adv = bus.next_pixel && bus.bground_read;
    for (int s = 0; s < N; s++) begin
      if (bus.line_clear) begin
        m_valid[s] = 0;
        m_armed[s] = 0;
      end else if (bus.pattern0_ld && int'(bus.load_slot) == s) begin
        m_valid[s] = bus.valid_sprite;
        m_flip[s]  = bus.sprite_attr_in[3];
        m_pri[s]   = bus.sprite_attr_in[2];
        m_pal[s]   = bus.sprite_attr_in[1:0];
        m_x[s]     = int'(bus.sprite_x_in);
        m_lo[s]    = bus.pattern_in;
        m_armed[s] = 0;
        m_cnt[s]   = 0;
      end else if (bus.pattern1_ld && int'(bus.load_slot) == s) begin
        m_hi[s]    = bus.pattern_in;
        m_armed[s] = 1;
        m_cnt[s]   = 0;
      end else if (adv && m_armed[s]) begin
        m_cnt[s]++;
      end
    end
  endtask

  function automatic logic [8:0] model_out();
    logic [8:0] r;
    bit found;
    int i;
    logic lb, hb;
    r = '0;
    found = 0;
    for (int s = 0; s < N; s++) begin
      if (m_valid[s] && m_armed[s] && m_cnt[s] >= m_x[s] && m_cnt[s] < m_x[s] + 8) begin
        i  = m_cnt[s] - m_x[s];
        lb = m_flip[s] ? m_lo[s][i] : m_lo[s][7-i];
        hb = m_flip[s] ? m_hi[s][i] : m_hi[s][7-i];
        if (hb || lb) begin
          if (s == 0) r[0] = 1'b1;
          if (!found) begin
            found  = 1;
            r[8:1] = {m_pal[s], hb, lb, m_pri[s], 3'(s)};
          end
        end
      end
    end
    return r;
  endfunction

  // driver tasks
  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.bground_read = 0; bus.next_pixel = 0; bus.line_clear = 0;
    bus.load_slot = '0; bus.pattern0_ld = 0; bus.pattern1_ld = 0;
    bus.valid_sprite = 0; bus.sprite_attr_in = '0; bus.sprite_x_in = '0;
    bus.pattern_in = '0;
  endtask

  task automatic clear_line();
    bus.line_clear = 1;
    tick();
    bus.line_clear = 0;
  endtask

  task automatic load(input int slot, input logic vs, input logic [3:0] attr,
                      input logic [7:0] x, input logic [7:0] lo, input logic [7:0] hi);
    bus.load_slot = SW'(slot);
    bus.pattern0_ld = 1; bus.valid_sprite = vs; bus.sprite_attr_in = attr;
    bus.sprite_x_in = x; bus.pattern_in = lo;
    tick();
    bus.pattern0_ld = 0; bus.pattern1_ld = 1; bus.pattern_in = hi;
    tick();
    bus.pattern1_ld = 0;
  endtask

  // tests
  task automatic test_reset();
    rst = 1;
    idle_inputs();
    model_reset();
    #3;
    total++;
    if (obs !== 9'd0) begin bad++; $display("FAIL reset_init obs=%h exp=%h", obs, 9'd0); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    clear_line();
    load(0, 1, 4'b0011, 8'd0, 8'hFF, 8'hFF);
    bus.bground_read = 1; bus.next_pixel = 1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs !== 9'b1111_0_000_1) begin bad++; $display("FAIL reset_preline dot=%0d obs=%h exp=%h", d, obs, 9'b1111_0_000_1); end
      tick();
    end
    #2 rst = 1;
    #1;
    total++;
    if (obs !== 9'd0) begin bad++; $display("FAIL reset_async obs=%h exp=%h", obs, 9'd0); end
    model_reset();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    for (int d = 0; d < 10; d++) begin
      total++;
      if (obs !== 9'd0) begin bad++; $display("FAIL reset_after dot=%0d obs=%h exp=%h", d, obs, 9'd0); end
      tick();
    end
    bus.next_pixel = 0;
  endtask

  task automatic test_single();
    logic [8:0] e;
    clear_line();
    load(2, 1, 4'b0001, 8'd3, 8'h81, 8'h80);
    bus.bground_read = 1; bus.next_pixel = 1;
    for (int d = 0; d < 16; d++) begin
      e = (d == 3) ? {4'b0111, 1'b0, 3'd2, 1'b0} :
          (d == 10) ? {4'b0101, 1'b0, 3'd2, 1'b0} : 9'd0;
      total++;
      if (obs !== e) begin bad++; $display("FAIL single dot=%0d obs=%h exp=%h", d, obs, e); end
      tick();
    end
    bus.next_pixel = 0;
  endtask

  task automatic test_flip();
    logic [8:0] e;
    clear_line();
    load(2, 1, 4'b1001, 8'd3, 8'h01, 8'h00);
    bus.bground_read = 1; bus.next_pixel = 1;
    for (int d = 0; d < 16; d++) begin
      e = (d == 3) ? {4'b0101, 1'b0, 3'd2, 1'b0} : 9'd0;
      total++;
      if (obs !== e) begin bad++; $display("FAIL flip dot=%0d obs=%h exp=%h", d, obs, e); end
      tick();
    end
    bus.next_pixel = 0;
  endtask

  task automatic test_overlap();
    logic [8:0] e;
    clear_line();
    load(0, 1, 4'b0100, 8'd0, 8'hF0, 8'h00);
    load(1, 1, 4'b0000, 8'd2, 8'hFF, 8'h00);
    bus.bground_read = 1; bus.next_pixel = 1;
    for (int d = 0; d < 14; d++) begin
      e = (d < 4)  ? {4'b0001, 1'b1, 3'd0, 1'b1} :
          (d < 10) ? {4'b0001, 1'b0, 3'd1, 1'b0} : 9'd0;
      total++;
      if (obs !== e) begin bad++; $display("FAIL overlap dot=%0d obs=%h exp=%h", d, obs, e); end
      tick();
    end
    bus.next_pixel = 0;
  endtask

  task automatic test_invalid_clear();
    clear_line();
    load(0, 0, 4'b0011, 8'd0, 8'hFF, 8'hFF);
    bus.load_slot = 3'd3;
    bus.pattern0_ld = 1; bus.valid_sprite = 1; bus.sprite_attr_in = 4'b0010;
    bus.sprite_x_in = 8'd1; bus.pattern_in = 8'hFF;
    tick();
    bus.pattern0_ld = 0; bus.pattern1_ld = 1; bus.line_clear = 1; bus.pattern_in = 8'hFF;
    tick();
    bus.pattern1_ld = 0; bus.line_clear = 0;
    bus.bground_read = 1; bus.next_pixel = 1;
    for (int d = 0; d < 12; d++) begin
      total++;
      if (obs !== 9'd0) begin bad++; $display("FAIL invalid_clear dot=%0d obs=%h exp=%h", d, obs, 9'd0); end
      tick();
    end
    bus.next_pixel = 0;
  endtask

  task automatic test_freeze();
    logic [8:0] held;
    logic [8:0] e;
    clear_line();
    load(1, 1, 4'b0110, 8'd1, 8'hA5, 8'h3C);
    bus.bground_read = 1; bus.next_pixel = 1;
    for (int d = 0; d < 4; d++) begin
      e = model_out();
      total++;
      if (obs !== e) begin bad++; $display("FAIL freeze_pre dot=%0d obs=%h exp=%h", d, obs, e); end
      tick();
    end
    held = model_out();
    bus.bground_read = 0;
    for (int c = 0; c < 5; c++) begin
      bus.next_pixel = c[0];
      tick();
      total++;
      if (obs !== held) begin bad++; $display("FAIL freeze_hold cyc=%0d obs=%h exp=%h", c, obs, held); end
    end
    bus.bground_read = 1; bus.next_pixel = 1;
    for (int d = 4; d < 14; d++) begin
      e = model_out();
      total++;
      if (obs !== e) begin bad++; $display("FAIL freeze_resume dot=%0d obs=%h exp=%h", d, obs, e); end
      tick();
    end
    bus.next_pixel = 0;
  endtask

  task automatic test_x_wrap();
    logic [8:0] e;
    clear_line();
    load(4, 1, 4'b0010, 8'd255, 8'hFF, 8'h00);
    bus.bground_read = 1; bus.next_pixel = 1;
    for (int d = 0; d < 266; d++) begin
      e = model_out();
      if (d == 255 || d == 262 || d == 263) begin
        total++;
        if (obs !== e) begin bad++; $display("FAIL x_wrap dot=%0d obs=%h exp=%h", d, obs, e); end
      end
      tick();
    end
    total++;
    if (obs !== 9'd0) begin bad++; $display("FAIL x_wrap_end obs=%h exp=%h", obs, 9'd0); end
    bus.next_pixel = 0;
  endtask

  task automatic test_random();
    int pend;
    logic [8:0] e;
    for (int line = 0; line < 8; line++) begin
      bus.bground_read = 0; bus.next_pixel = 0;
      clear_line();
      for (int s = 0; s < N; s++) begin
        if ($urandom_range(0, 3) != 0)
          load(s, $urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)),
               8'($urandom_range(0, 24)), 8'($urandom), 8'($urandom));
      end
      pend = -1;
      for (int c = 0; c < 48; c++) begin
        bus.bground_read = ($urandom_range(0, 7) != 0);
        bus.next_pixel   = ($urandom_range(0, 3) != 0);
        if (pend >= 0) begin
          bus.load_slot = SW'(pend); bus.pattern1_ld = 1; bus.pattern_in = 8'($urandom);
          pend = -1;
        end else if ($urandom_range(0, 11) == 0) begin
          pend = $urandom_range(0, N - 1);
          bus.load_slot = SW'(pend); bus.pattern0_ld = 1;
          bus.valid_sprite = ($urandom_range(0, 7) != 0);
          bus.sprite_attr_in = 4'($urandom_range(0, 15));
          bus.sprite_x_in = 8'($urandom_range(0, 12));
          bus.pattern_in = 8'($urandom);
        end
        exp_q.push_back(model_out());
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL random line=%0d cyc=%0d obs=%h exp=%h", line, c, obs, e); end
        tick();
        bus.pattern0_ld = 0; bus.pattern1_ld = 0;
      end
      if (pend >= 0) begin
        bus.load_slot = SW'(pend); bus.pattern1_ld = 1; bus.pattern_in = 8'($urandom);
        tick();
        bus.pattern1_ld = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_flip();
    test_overlap();
    test_invalid_clear();
    test_freeze();
    test_x_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
